// File: rtl/instr_fetch_queue.sv
// Instruction fetch front end: credit-limited sequential fetch, in-order response
// buffering with PC pairing, and redirect flush that discards stale in-flight words.
module instr_fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        mem_req_valid,
    output logic [63:0] mem_req_addr,
    input  logic        mem_req_ready,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_data,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [63:0] instr_pc,
    input  logic        instr_ready
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW:0]  DEPTH_W          = (CW + 1)'(DEPTH);
    localparam logic [63:0]  RESET_PC_ALIGNED = RESET_PC & ~64'h3;

    logic [63:0]   fetch_pc;
    logic [63:0]   redirect_pc_aligned;
    logic [63:0]   pc_mem   [DEPTH];
    logic [31:0]   word_mem [DEPTH];
    logic [63:0]   rq_mem   [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr, rq_wr_ptr, rq_rd_ptr;
    logic [CW-1:0] count, outstanding, drop;
    logic [CW-1:0] count_nxt, outstanding_nxt;
    logic          req_fire, rsp_drop, rsp_push, pop;

    assign redirect_pc_aligned = redirect_pc & ~64'h3;

    // Issue only while every accepted request is guaranteed a buffer slot.
    assign mem_req_valid = rst_n && !redirect_valid &&
                           (({1'b0, count} + {1'b0, outstanding}) < DEPTH_W);
    assign mem_req_addr  = fetch_pc;
    assign req_fire      = mem_req_valid && mem_req_ready;

    assign rsp_drop = mem_rsp_valid && (redirect_valid || drop != '0);
    assign rsp_push = mem_rsp_valid && !rsp_drop;

    assign instr_valid = count != '0;
    assign pop         = instr_valid && instr_ready && !redirect_valid;
    assign instr       = instr_valid ? word_mem[rd_ptr] : '0;
    assign instr_pc    = instr_valid ? pc_mem[rd_ptr]   : '0;

    always_comb begin
        outstanding_nxt = outstanding;
        if (req_fire)
            outstanding_nxt = outstanding_nxt + CW'(1);
        if (mem_rsp_valid)
            outstanding_nxt = outstanding_nxt - CW'(1);
    end

    always_comb begin
        count_nxt = count;
        if (rsp_push)
            count_nxt = count_nxt + CW'(1);
        if (pop)
            count_nxt = count_nxt - CW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc    <= RESET_PC_ALIGNED;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            rq_wr_ptr   <= '0;
            rq_rd_ptr   <= '0;
            count       <= '0;
            outstanding <= '0;
            drop        <= '0;
        end else begin
            outstanding <= outstanding_nxt;
            if (req_fire) begin
                fetch_pc  <= fetch_pc + 64'd4;
                rq_wr_ptr <= rq_wr_ptr + AW'(1);
            end
            // Every response, kept or dropped, retires its request PC.
            if (mem_rsp_valid)
                rq_rd_ptr <= rq_rd_ptr + AW'(1);
            if (redirect_valid) begin
                fetch_pc <= redirect_pc_aligned;
                count    <= '0;
                rd_ptr   <= wr_ptr;
                drop     <= outstanding_nxt;
            end else begin
                count <= count_nxt;
                if (rsp_drop)
                    drop <= drop - CW'(1);
                if (rsp_push)
                    wr_ptr <= wr_ptr + AW'(1);
                if (pop)
                    rd_ptr <= rd_ptr + AW'(1);
            end
        end
    end

    // Payload storage needs no reset; visibility is governed by count.
    always_ff @(posedge clk) begin
        if (rsp_push) begin
            pc_mem[wr_ptr]   <= rq_mem[rq_rd_ptr];
            word_mem[wr_ptr] <= mem_rsp_data;
        end
        if (req_fire)
            rq_mem[rq_wr_ptr] <= fetch_pc;
    end

endmodule
